// File: rtl/rv_dec_pkg.sv
// Shared opcode constants, control encodings and the decoded-control bundle
// passed from the decode core to the output register of rv_dec_queue.
package rv_dec_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        OPM_NONE  = 3'd0,
        OPM_LOGIC = 3'd1,
        OPM_SHIFT = 3'd2,
        OPM_CMP   = 3'd3,
        OPM_ADD   = 3'd4,
        OPM_MUL   = 3'd5,
        OPM_DIV   = 3'd6,
        OPM_REM   = 3'd7
    } op_mode_e;

    // func_op is interpreted relative to op_mode, so encodings overlap.
    localparam logic [2:0] FOP_AND = 3'b000;
    localparam logic [2:0] FOP_OR  = 3'b001;
    localparam logic [2:0] FOP_XOR = 3'b010;
    localparam logic [2:0] FOP_SLL = 3'b000;
    localparam logic [2:0] FOP_SRL = 3'b010;
    localparam logic [2:0] FOP_SRA = 3'b011;
    localparam logic [2:0] FOP_ADD = 3'b000;
    localparam logic [2:0] FOP_SUB = 3'b001;
    localparam logic [2:0] FOP_BEQ = 3'b110;
    localparam logic [2:0] FOP_BNE = 3'b010;
    localparam logic [2:0] FOP_BLT = 3'b000;
    localparam logic [2:0] FOP_BGE = 3'b101;

    typedef struct packed {
        logic        illegal;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] jump_imm;
        logic [2:0]  funct3;
        op_mode_e    op_mode;
        logic [2:0]  func_op;
        logic        ecall;
        logic        alusrc;
        logic        mem_to_reg;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        fp_mode;
    } dec_ctrl_t;

endpackage

// File: rtl/rv_dec_core.sv
// Purely combinational RV32I/M decoder: instruction word in, control bundle out.
// Illegal encodings keep their register fields but lose all side-effecting controls.
module rv_dec_core
    import rv_dec_pkg::*;
#(
    parameter bit EN_M     = 1'b1,
    parameter bit EN_AUIPC = 1'b0
) (
    input  logic [31:0] inst_i,
    output dec_ctrl_t   ctrl_o
);

    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  f3;
    logic [20:0] j_off;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
    dec_ctrl_t   c;
    logic        bad;

    assign opcode = inst_i[6:0];
    assign funct7 = inst_i[31:25];
    assign f3     = inst_i[14:12];
    assign j_off  = {inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
    assign imm_i  = {{20{inst_i[31]}}, inst_i[31:20]};
    assign imm_s  = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign imm_b  = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_u  = {inst_i[31:12], 12'b0};
    assign imm_j  = {{11{inst_i[31]}}, j_off};
    assign imm_sh = {27'd0, inst_i[24:20]};

    always_comb begin
        c        = '0;
        bad      = 1'b0;
        c.rd     = inst_i[11:7];
        c.rs1    = inst_i[19:15];
        c.rs2    = inst_i[24:20];
        c.funct3 = f3;
        case (opcode)
            OPC_LUI: begin
                c.imm       = imm_u;
                c.alusrc    = 1'b1;
                c.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                c.imm       = imm_u;
                c.alusrc    = 1'b1;
                c.reg_write = 1'b1;
                c.branch    = 1'b1;
                bad         = !EN_AUIPC;
            end
            OPC_JAL: begin
                c.imm       = imm_j;
                c.jump_imm  = {11'd0, j_off};
                c.reg_write = 1'b1;
                c.op_mode   = OPM_ADD;
            end
            OPC_JALR: begin
                c.imm       = imm_i;
                c.jump_imm  = {20'd1, inst_i[31:20]};
                c.alusrc    = 1'b1;
                c.reg_write = 1'b1;
                c.op_mode   = OPM_ADD;
                bad         = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                c.imm     = imm_b;
                c.branch  = 1'b1;
                c.op_mode = OPM_CMP;
                case (f3)
                    3'b000:          c.func_op = FOP_BEQ;
                    3'b001:          c.func_op = FOP_BNE;
                    3'b101, 3'b111:  c.func_op = FOP_BGE;
                    default:         c.func_op = FOP_BLT;
                endcase
            end
            OPC_LOAD: begin
                c.imm        = imm_i;
                c.alusrc     = 1'b1;
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
                c.mem_read   = 1'b1;
                c.op_mode    = OPM_ADD;
            end
            OPC_STORE: begin
                c.imm       = imm_s;
                c.alusrc    = 1'b1;
                c.mem_write = 1'b1;
                c.op_mode   = OPM_ADD;
            end
            OPC_OP_IMM: begin
                c.imm       = imm_i;
                c.alusrc    = 1'b1;
                c.reg_write = 1'b1;
                case (f3)
                    3'b000: c.op_mode = OPM_ADD;
                    3'b010, 3'b011: begin c.op_mode = OPM_CMP; c.func_op = FOP_BLT; end
                    3'b100: begin c.op_mode = OPM_LOGIC; c.func_op = FOP_XOR; end
                    3'b110: begin c.op_mode = OPM_LOGIC; c.func_op = FOP_OR; end
                    3'b111: begin c.op_mode = OPM_LOGIC; c.func_op = FOP_AND; end
                    3'b001: begin
                        c.imm     = imm_sh;
                        c.op_mode = OPM_SHIFT;
                        c.func_op = FOP_SLL;
                        bad       = (funct7 != F7_BASE);
                    end
                    default: begin
                        c.imm     = imm_sh;
                        c.op_mode = OPM_SHIFT;
                        c.func_op = (funct7 == F7_ALT) ? FOP_SRA : FOP_SRL;
                        bad       = (funct7 != F7_BASE) && (funct7 != F7_ALT);
                    end
                endcase
            end
            OPC_OP: begin
                c.reg_write = 1'b1;
                case (funct7)
                    F7_BASE: begin
                        case (f3)
                            3'b000: c.op_mode = OPM_ADD;
                            3'b001: begin c.op_mode = OPM_SHIFT; c.func_op = FOP_SLL; end
                            3'b010, 3'b011: begin c.op_mode = OPM_CMP; c.func_op = FOP_BLT; end
                            3'b100: begin c.op_mode = OPM_LOGIC; c.func_op = FOP_XOR; end
                            3'b101: begin c.op_mode = OPM_SHIFT; c.func_op = FOP_SRL; end
                            3'b110: begin c.op_mode = OPM_LOGIC; c.func_op = FOP_OR; end
                            default: begin c.op_mode = OPM_LOGIC; c.func_op = FOP_AND; end
                        endcase
                    end
                    F7_ALT: begin
                        case (f3)
                            3'b000: begin c.op_mode = OPM_ADD; c.func_op = FOP_SUB; end
                            3'b101: begin c.op_mode = OPM_SHIFT; c.func_op = FOP_SRA; end
                            default: bad = 1'b1;
                        endcase
                    end
                    F7_MULDIV: begin
                        // Only the signed low-word forms are implemented by execute.
                        case (f3)
                            3'b000:  c.op_mode = OPM_MUL;
                            3'b100:  c.op_mode = OPM_DIV;
                            3'b110:  c.op_mode = OPM_REM;
                            default: bad = 1'b1;
                        endcase
                        if (!EN_M) bad = 1'b1;
                    end
                    default: bad = 1'b1;
                endcase
            end
            OPC_SYSTEM: c.ecall = (inst_i[31:7] == 25'd0);
            default: bad = 1'b1;
        endcase
        if (bad) begin
            c.reg_write = 1'b0;
            c.mem_read  = 1'b0;
            c.mem_write = 1'b0;
            c.branch    = 1'b0;
            c.ecall     = 1'b0;
            c.op_mode   = OPM_NONE;
        end
        c.illegal = bad;
    end

    assign ctrl_o = c;

endmodule

// File: rtl/rv_dec_queue.sv
// Decode stage: DEPTH-entry fetch queue feeding a registered decode output,
// with valid/ready on both sides and a single-cycle flush.
module rv_dec_queue
    import rv_dec_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned PC_W     = 32,
    parameter bit          EN_M     = 1'b1,
    parameter bit          EN_AUIPC = 1'b0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_inst_data,
    input  logic [PC_W-1:0] i_pc,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [PC_W-1:0] o_pc,
    output logic            o_illegal,
    output logic [4:0]      o_rd,
    output logic [4:0]      o_rs1,
    output logic [4:0]      o_rs2,
    output logic [31:0]     o_imm,
    output logic [31:0]     o_jump_imm,
    output logic [2:0]      o_funct3,
    output logic [2:0]      o_op_mode,
    output logic [2:0]      o_func_op,
    output logic            o_ecall,
    output logic            o_alusrc,
    output logic            o_mem_to_reg,
    output logic            o_reg_write,
    output logic            o_mem_read,
    output logic            o_mem_write,
    output logic            o_branch,
    output logic            o_fp_mode
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0]      inst_mem_q [DEPTH];
    logic [PC_W-1:0]  pc_mem_q   [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [PC_W-1:0]  out_pc_q, out_pc_d;
    dec_ctrl_t        out_ctrl_q, out_ctrl_d, head_ctrl;
    logic             full, empty, push, pop;

    // Full is judged on the registered count only, so a same-cycle pop never opens a slot.
    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign push    = i_valid && !full;
    assign pop     = !empty && (!out_valid_q || i_ready);
    assign o_ready = !full;

    rv_dec_core #(
        .EN_M     (EN_M),
        .EN_AUIPC (EN_AUIPC)
    ) u_core (
        .inst_i (inst_mem_q[rd_ptr_q]),
        .ctrl_o (head_ctrl)
    );

    always_ff @(posedge i_clk) begin
        if (push && !i_flush) begin
            inst_mem_q[wr_ptr_q] <= i_inst_data;
            pc_mem_q[wr_ptr_q]   <= i_pc;
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_ctrl_d  = out_ctrl_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop) begin
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            out_valid_d = 1'b1;
            out_pc_d    = pc_mem_q[rd_ptr_q];
            out_ctrl_d  = head_ctrl;
        end else if (i_ready) begin
            out_valid_d = 1'b0;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        if (i_flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            out_pc_d    = out_pc_q;
            out_ctrl_d  = out_ctrl_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_ctrl_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_ctrl_q  <= out_ctrl_d;
        end
    end

    assign o_valid      = out_valid_q;
    assign o_pc         = out_pc_q;
    assign o_illegal    = out_ctrl_q.illegal;
    assign o_rd         = out_ctrl_q.rd;
    assign o_rs1        = out_ctrl_q.rs1;
    assign o_rs2        = out_ctrl_q.rs2;
    assign o_imm        = out_ctrl_q.imm;
    assign o_jump_imm   = out_ctrl_q.jump_imm;
    assign o_funct3     = out_ctrl_q.funct3;
    assign o_op_mode    = out_ctrl_q.op_mode;
    assign o_func_op    = out_ctrl_q.func_op;
    assign o_ecall      = out_ctrl_q.ecall;
    assign o_alusrc     = out_ctrl_q.alusrc;
    assign o_mem_to_reg = out_ctrl_q.mem_to_reg;
    assign o_reg_write  = out_ctrl_q.reg_write;
    assign o_mem_read   = out_ctrl_q.mem_read;
    assign o_mem_write  = out_ctrl_q.mem_write;
    assign o_branch     = out_ctrl_q.branch;
    assign o_fp_mode    = out_ctrl_q.fp_mode;

endmodule

// File: tb/tb_rv_dec_queue.sv
// Directed bench for rv_dec_queue: queue flow control, ordering, flush and
// decode of hand-encoded instructions; a second instance has MUL/DIV disabled.
module tb_rv_dec_queue;

    logic        clk = 1'b0;
    logic        rst, flush, vld, rdy;
    logic [31:0] inst, pc;

    logic        o_ready, o_valid, o_illegal;
    logic [31:0] o_pc, o_imm, o_jump_imm;
    logic [4:0]  o_rd, o_rs1, o_rs2;
    logic [2:0]  o_funct3, o_op_mode, o_func_op;
    logic        o_ecall, o_alusrc, o_mem_to_reg, o_reg_write, o_mem_read, o_mem_write, o_branch, o_fp_mode;

    logic        n_ready, n_valid, n_illegal;
    logic [31:0] n_pc, n_imm, n_jump_imm;
    logic [4:0]  n_rd, n_rs1, n_rs2;
    logic [2:0]  n_funct3, n_op_mode, n_func_op;
    logic        n_ecall, n_alusrc, n_mem_to_reg, n_reg_write, n_mem_read, n_mem_write, n_branch, n_fp_mode;

    int n_cmp = 0;
    int n_err = 0;

    rv_dec_queue #(.DEPTH(4), .PC_W(32), .EN_M(1'b1), .EN_AUIPC(1'b0)) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(vld), .o_ready(o_ready),
        .i_inst_data(inst), .i_pc(pc), .o_valid(o_valid), .i_ready(rdy), .o_pc(o_pc),
        .o_illegal(o_illegal), .o_rd(o_rd), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_imm(o_imm),
        .o_jump_imm(o_jump_imm), .o_funct3(o_funct3), .o_op_mode(o_op_mode), .o_func_op(o_func_op),
        .o_ecall(o_ecall), .o_alusrc(o_alusrc), .o_mem_to_reg(o_mem_to_reg), .o_reg_write(o_reg_write),
        .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_branch(o_branch), .o_fp_mode(o_fp_mode)
    );

    rv_dec_queue #(.DEPTH(4), .PC_W(32), .EN_M(1'b0), .EN_AUIPC(1'b0)) dut_nm (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(vld), .o_ready(n_ready),
        .i_inst_data(inst), .i_pc(pc), .o_valid(n_valid), .i_ready(rdy), .o_pc(n_pc),
        .o_illegal(n_illegal), .o_rd(n_rd), .o_rs1(n_rs1), .o_rs2(n_rs2), .o_imm(n_imm),
        .o_jump_imm(n_jump_imm), .o_funct3(n_funct3), .o_op_mode(n_op_mode), .o_func_op(n_func_op),
        .o_ecall(n_ecall), .o_alusrc(n_alusrc), .o_mem_to_reg(n_mem_to_reg), .o_reg_write(n_reg_write),
        .o_mem_read(n_mem_read), .o_mem_write(n_mem_write), .o_branch(n_branch), .o_fp_mode(n_fp_mode)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One instruction through an idle pipe with i_ready=1; decoded result is held afterwards.
    task automatic send(input logic [31:0] w, input logic [31:0] p);
        inst = w;
        pc   = p;
        vld  = 1'b1;
        tick();
        vld  = 1'b0;
        tick();
    endtask

    function automatic logic [31:0] addi(input int r);
        logic [31:0] v;
        v = r;
        return {v[11:0], 5'd0, 3'b000, v[4:0], 7'b0010011};
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; vld = 1'b0; rdy = 1'b0; inst = '0; pc = '0;
        tick();
        tick();
        chk("rst_valid", o_valid, 0);
        chk("rst_ready", o_ready, 1);
        chk("rst_pc", o_pc, 0);
        chk("rst_imm", o_imm, 0);
        chk("rst_illegal", o_illegal, 0);
        chk("rst_rd", o_rd, 0);
        rst = 1'b0;
        tick();

        // ADDI x1,x2,-5: queued on the first edge, visible after the second
        rdy = 1'b1; inst = 32'hFFB10093; pc = 32'h100; vld = 1'b1;
        tick();
        vld = 1'b0;
        chk("addi_lat_valid0", o_valid, 0);
        tick();
        chk("addi_valid", o_valid, 1);
        chk("addi_rd", o_rd, 1);
        chk("addi_rs1", o_rs1, 2);
        chk("addi_imm", o_imm, 32'hFFFFFFFB);
        chk("addi_opmode", o_op_mode, 4);
        chk("addi_pc", o_pc, 32'h100);
        chk("addi_memread", o_mem_read, 0);
        chk("addi_regwrite", o_reg_write, 1);
        tick();
        chk("addi_drain", o_valid, 0);

        // Fill: 4 queued + 1 held with execute stalled
        rdy = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            chk("fill_ready_before", o_ready, 1);
            inst = addi(i); pc = 32'h200 + 4 * i; vld = 1'b1;
            tick();
        end
        vld = 1'b0;
        chk("fill_ready_full", o_ready, 0);
        chk("fill_valid", o_valid, 1);
        chk("fill_head_pc", o_pc, 32'h204);
        tick();
        chk("stall_hold_pc", o_pc, 32'h204);
        chk("stall_hold_rd", o_rd, 1);
        chk("stall_ready", o_ready, 0);
        rdy = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            chk("drain_valid", o_valid, 1);
            chk("drain_rd", o_rd, i);
            chk("drain_pc", o_pc, 32'h200 + 4 * i);
            tick();
        end
        chk("drain_empty_valid", o_valid, 0);
        chk("drain_ready", o_ready, 1);

        // Sustained stream across pointer wrap
        for (int i = 1; i <= 10; i++) begin
            inst = addi(i); pc = 32'h300 + 4 * i; vld = 1'b1;
            tick();
            chk("stream_ready", o_ready, 1);
            if (i > 1) begin
                chk("stream_valid", o_valid, 1);
                chk("stream_rd", o_rd, i - 1);
                chk("stream_pc", o_pc, 32'h300 + 4 * (i - 1));
            end
        end
        vld = 1'b0;
        tick();
        chk("stream_last_valid", o_valid, 1);
        chk("stream_last_rd", o_rd, 10);
        tick();
        chk("stream_end_valid", o_valid, 0);

        // Flush with 3 queued + 1 held and a simultaneous push
        rdy = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            inst = addi(20 + i); pc = 32'h400 + 4 * i; vld = 1'b1;
            tick();
        end
        inst = addi(31); pc = 32'h999; vld = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; vld = 1'b0;
        chk("flush_valid", o_valid, 0);
        chk("flush_ready", o_ready, 1);
        rdy = 1'b1;
        tick();
        chk("flush_no_push_1", o_valid, 0);
        tick();
        chk("flush_no_push_2", o_valid, 0);
        send(addi(7), 32'h500);
        chk("post_flush_rd", o_rd, 7);
        chk("post_flush_pc", o_pc, 32'h500);

        // MUL x3,x1,x2 with and without the M extension
        send(32'h022081B3, 32'h600);
        chk("mul_m_opmode", o_op_mode, 5);
        chk("mul_m_illegal", o_illegal, 0);
        chk("mul_m_regwrite", o_reg_write, 1);
        chk("mul_nm_valid", n_valid, 1);
        chk("mul_nm_illegal", n_illegal, 1);
        chk("mul_nm_regwrite", n_reg_write, 0);
        chk("mul_nm_opmode", n_op_mode, 0);
        chk("mul_nm_pc", n_pc, 32'h600);

        // MULHU is never supported
        send(32'h0220B1B3, 32'h604);
        chk("mulhu_illegal", o_illegal, 1);

        // BNE x1,x2,-8
        send(32'hFE209CE3, 32'h700);
        chk("bne_funcop", o_func_op, 3'b010);
        chk("bne_branch", o_branch, 1);
        chk("bne_imm", o_imm, 32'hFFFFFFF8);
        chk("bne_illegal", o_illegal, 0);
        chk("bne_regwrite", o_reg_write, 0);

        // JALR with funct3=010
        send(32'h000120E7, 32'h704);
        chk("jalr_bad_illegal", o_illegal, 1);
        chk("jalr_bad_regwrite", o_reg_write, 0);
        chk("jalr_bad_pc", o_pc, 32'h704);

        // JALR x1,4(x2)
        send(32'h004100E7, 32'h708);
        chk("jalr_illegal", o_illegal, 0);
        chk("jalr_jimm", o_jump_imm, 32'h00001004);
        chk("jalr_imm", o_imm, 4);

        // JAL x1,+16
        send(32'h010000EF, 32'h70C);
        chk("jal_jimm", o_jump_imm, 32'h10);
        chk("jal_imm", o_imm, 16);

        // SRAI x1,x2,3 (zero-extended shamt) and SUB x3,x1,x2
        send(32'h40315093, 32'h710);
        chk("srai_imm", o_imm, 3);
        chk("srai_funcop", o_func_op, 3'b011);
        chk("srai_opmode", o_op_mode, 2);
        send(32'h402081B3, 32'h714);
        chk("sub_funcop", o_func_op, 3'b001);
        chk("sub_opmode", o_op_mode, 4);

        // Bad funct7 on OP, AUIPC disabled, unknown opcode
        send(32'h042081B3, 32'h718);
        chk("op_f7_illegal", o_illegal, 1);
        send(32'h12345297, 32'h71C);
        chk("auipc_illegal", o_illegal, 1);
        chk("auipc_branch", o_branch, 0);
        send(32'h0000007F, 32'h720);
        chk("unknown_illegal", o_illegal, 1);

        // SW x2,-4(x1)
        send(32'hFE20AE23, 32'h724);
        chk("sw_imm", o_imm, 32'hFFFFFFFC);
        chk("sw_memwrite", o_mem_write, 1);
        chk("sw_regwrite", o_reg_write, 0);

        // Asynchronous reset between clock edges
        send(addi(9), 32'h800);
        chk("arst_pre_valid", o_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", o_valid, 0);
        chk("arst_pc", o_pc, 0);
        chk("arst_rd", o_rd, 0);
        chk("arst_ready", o_ready, 1);
        tick();
        rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
